// File: rtl/max10nios_votingctrl_out.sv
// Avalon-MM output PIO for the voting control word, with a programmable-length command strobe.
// Optional MAX10NIOS_VOTINGCTRL_AUTOCLR_EN: data returns to RESET_VALUE when the strobe ends.
module max10nios_votingctrl_out #(
   parameter int unsigned DATA_WIDTH  = 1,
   parameter logic [31:0] RESET_VALUE = 32'd0,
   parameter logic [15:0] PULSE_RESET = 16'd1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  out_strobe
);

   logic                  wr;
   logic                  data_wr;
   logic                  busy;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [15:0]           pulse_len_q, pulse_len_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  strobe_q, strobe_d;
   logic [31:0]           readdata_q, readdata_d;
   logic                  unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign data_wr      = wr & (address != 2'd1);
   assign busy         = (cnt_q != 16'd0);
   assign unused_wdata = ^writedata;

   always_comb begin
      data_d      = data_q;
      pulse_len_d = pulse_len_q;
      if (wr) begin
         case (address)
            2'd0:    data_d = writedata[DATA_WIDTH-1:0];
            2'd1:    pulse_len_d = writedata[15:0];
            2'd2:    data_d = data_q | writedata[DATA_WIDTH-1:0];
            default: data_d = data_q & ~writedata[DATA_WIDTH-1:0];
         endcase
      end
`ifdef MAX10NIOS_VOTINGCTRL_AUTOCLR_EN
      // Command retracts on the terminal count edge unless software rewrites it there.
      if (!data_wr && cnt_q == 16'd1) begin
         data_d = RESET_VALUE[DATA_WIDTH-1:0];
      end
`endif

      // Any data-path write restarts the pulse; PULSE writes only affect later pulses.
      if (data_wr) begin
         cnt_d = pulse_len_q;
      end else if (busy) begin
         cnt_d = cnt_q - 16'd1;
      end else begin
         cnt_d = 16'd0;
      end
      strobe_d = (cnt_d != 16'd0);

      readdata_d = 32'd0;
      case (address)
         2'd0:    readdata_d[DATA_WIDTH-1:0] = data_q;
         2'd1:    readdata_d = {busy, 15'd0, pulse_len_q};
         2'd2:    readdata_d = {16'd0, cnt_q};
         default: readdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q      <= RESET_VALUE[DATA_WIDTH-1:0];
         pulse_len_q <= PULSE_RESET;
         cnt_q       <= 16'd0;
         strobe_q    <= 1'b0;
         readdata_q  <= 32'd0;
      end else begin
         data_q      <= data_d;
         pulse_len_q <= pulse_len_d;
         cnt_q       <= cnt_d;
         strobe_q    <= strobe_d;
         readdata_q  <= readdata_d;
      end
   end

   assign out_port   = data_q;
   assign out_strobe = strobe_q;
   assign readdata   = readdata_q;

endmodule

// File: tb/tb_max10nios_votingctrl_out.sv
// Directed table-driven bench for max10nios_votingctrl_out (default parameters).
module tb_max10nios_votingctrl_out;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [0:0]  out_port;
   logic        out_strobe;

   int n_vec = 0;
   int n_err = 0;

`ifdef MAX10NIOS_VOTINGCTRL_AUTOCLR_EN
   localparam logic [31:0] PH = 32'd0;
`else
   localparam logic [31:0] PH = 32'd1;
`endif

   typedef struct {
      logic [1:0]  addr;
      logic        cs;
      logic        wn;
      logic [31:0] wd;
      logic [31:0] e_port;
      logic        e_strb;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl[$];

   max10nios_votingctrl_out dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .out_strobe (out_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
      @(negedge clk);
      address    = a;
      chipselect = cs;
      write_n    = wn;
      writedata  = wd;
      @(posedge clk);
      #1;
      $display("t=%0t addr=%0d cs=%0b wn=%0b wd=%h -> port=%0d strobe=%0b rd=%h",
               $time, a, cs, wn, wd, out_port, out_strobe, readdata);
   endtask

   task automatic chk3(input string name, input logic [31:0] ep, input logic es, input logic [31:0] er);
      chk({name, ".port"}, 32'(out_port), ep);
      chk({name, ".strobe"}, 32'(out_strobe), 32'(es));
      chk({name, ".rd"}, readdata, er);
   endtask

   task automatic add(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                      input logic [31:0] ep, input logic es, input logic [31:0] er);
      vec_t v;
      v.addr = a; v.cs = cs; v.wn = wn; v.wd = wd;
      v.e_port = ep; v.e_strb = es; v.e_rd = er;
      tbl.push_back(v);
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;

      // addr cs wn writedata  port strobe readdata
      add(2'd0, 0, 1, 32'h0,        32'd0, 0, 32'h0);        // idle read data
      add(2'd0, 1, 0, 32'h1,        32'd1, 1, 32'h0);        // DATA=1, 1-cycle pulse
      add(2'd0, 0, 1, 32'h0,        PH,    0, 32'h1);
      add(2'd1, 0, 1, 32'h0,        PH,    0, 32'h1);        // PULSE reset value
      add(2'd1, 1, 0, 32'h4,        PH,    0, 32'h1);        // pulse_len=4
      add(2'd2, 1, 0, 32'h1,        32'd1, 1, 32'h0);        // OUTSET starts pulse
      add(2'd1, 0, 1, 32'h0,        32'd1, 1, 32'h80000004);
      add(2'd2, 0, 1, 32'h0,        32'd1, 1, 32'h3);
      add(2'd2, 0, 1, 32'h0,        32'd1, 1, 32'h2);
      add(2'd2, 0, 1, 32'h0,        PH,    0, 32'h1);
      add(2'd1, 0, 1, 32'h0,        PH,    0, 32'h4);
      add(2'd2, 0, 1, 32'h0,        PH,    0, 32'h0);
      add(2'd3, 1, 0, 32'h1,        32'd0, 1, 32'h0);        // OUTCLEAR, cycle 0
      add(2'd1, 1, 0, 32'h8,        32'd0, 1, 32'h80000004); // late length change
      add(2'd0, 1, 0, 32'h1,        32'd1, 1, 32'h0);        // retrigger with len 8
      for (int i = 8; i >= 2; i--) add(2'd2, 0, 1, 32'h0, 32'd1, 1, 32'(i));
      add(2'd2, 0, 1, 32'h0,        PH,    0, 32'h1);        // strobe falls after 10 cycles
      add(2'd1, 1, 0, 32'h0,        PH,    0, 32'h8);        // pulse_len=0
      add(2'd0, 1, 0, 32'h1,        32'd1, 0, PH);           // no strobe
      add(2'd1, 0, 1, 32'h0,        32'd1, 0, 32'h0);        // busy=0, len=0
      add(2'd3, 0, 1, 32'h0,        32'd1, 0, 32'h0);        // OUTCLEAR reads 0
      add(2'd0, 0, 0, 32'h0,        32'd1, 0, 32'h1);        // write without chipselect
      add(2'd3, 1, 1, 32'h1,        32'd1, 0, 32'h0);        // chipselect without write
      add(2'd0, 1, 0, 32'hFFFFFFFE, 32'd0, 0, 32'h1);        // upper bits ignored
      add(2'd0, 0, 1, 32'h0,        32'd0, 0, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      chk3("reset", 32'd0, 1'b0, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd);
         chk3($sformatf("vec%0d", i), tbl[i].e_port, tbl[i].e_strb, tbl[i].e_rd);
      end

      // Asynchronous reset in the middle of a pulse (cnt=5).
      cyc(2'd1, 1, 0, 32'h8);
      cyc(2'd0, 1, 0, 32'h1);
      repeat (3) cyc(2'd0, 0, 1, 32'h0);
      chk("pre_rst.cnt_read", 32'(dut.cnt_q), 32'd5);
      chk3("pre_rst", 32'd1, 1'b1, 32'h1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk3("async_rst", 32'd0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      chk3("held_rst", 32'd0, 1'b0, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(2'd1, 0, 1, 32'h0);
      chk3("post_rst.pulse", 32'd0, 1'b0, 32'h1);
      cyc(2'd2, 0, 1, 32'h0);
      chk3("post_rst.cnt", 32'd0, 1'b0, 32'h0);

      // Terminal-edge behaviour with pulse_len=3.
      cyc(2'd1, 1, 0, 32'h3);
      cyc(2'd0, 1, 0, 32'h1);
      chk3("term.w", 32'd1, 1'b1, 32'h0);
      cyc(2'd0, 0, 1, 32'h0);
      chk3("term.c2", 32'd1, 1'b1, 32'h1);
      cyc(2'd0, 0, 1, 32'h0);
      chk3("term.c1", 32'd1, 1'b1, 32'h1);
      cyc(2'd0, 0, 1, 32'h0);
      chk3("term.end", PH, 1'b0, 32'h1);
      cyc(2'd0, 1, 0, 32'h1);
      chk3("term2.w", 32'd1, 1'b1, PH);
      cyc(2'd0, 0, 1, 32'h0);
      cyc(2'd0, 0, 1, 32'h0);
      chk3("term2.c1", 32'd1, 1'b1, 32'h1);
      cyc(2'd0, 1, 0, 32'h1);
      chk3("term2.rewrite", 32'd1, 1'b1, 32'h1);
      cyc(2'd0, 0, 1, 32'h0);
      chk3("term2.r2", 32'd1, 1'b1, 32'h1);
      cyc(2'd0, 0, 1, 32'h0);
      chk3("term2.r1", 32'd1, 1'b1, 32'h1);
      cyc(2'd0, 0, 1, 32'h0);
      chk3("term2.end", PH, 1'b0, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/max10nios_votingctrl_out.md
Name: max10nios_votingctrl_out

Overview:
- Avalon-MM slave output PIO. It is the write-side counterpart of the VotingDone input PIO.
- The Nios II CPU writes a control word that drives `out_port`, for example a start or enable into the voting logic.
- Any data-changing write also launches a programmable-width strobe pulse on `out_strobe`, so downstream logic sees a clean "new command" event.
- Readback and status are available on `readdata` with the same registered one-cycle read latency as the other PIO slaves.

Parameters:
- DATA_WIDTH, 1, width of `out_port` and of the data register (1..32).
- RESET_VALUE, 0, value of the data register after reset.
- PULSE_RESET, 16'd1, value of the pulse-length register after reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  DATA_WIDTH  data register contents.
- out_strobe  output  1  command pulse, high for pulse_len cycles.

Behaviour:
- Write enable: wr = chipselect & ~write_n. Writes are single-cycle, with no wait states. Only writedata[DATA_WIDTH-1:0] is used for data writes; the upper bits are ignored.
- Register map:
  - addr 0, DATA: write loads data. Read returns data, zero-extended.
  - addr 1, PULSE: write loads pulse_len = writedata[15:0]. Read returns {busy, 15'b0, pulse_len}.
  - addr 2, OUTSET: write sets data |= writedata. Read returns the current cnt, zero-extended.
  - addr 3, OUTCLEAR: write clears data &= ~writedata. Read returns 0.
- Reads:
  - readdata is updated every clk edge from the address mux, independent of chipselect. The clock enable is tied to 1.
  - Read latency is 1 cycle.
  - Reads have no side effects.
- Strobe counter (16-bit cnt; busy = (cnt != 0)):
  - A wr to addr 0, 2 or 3 loads cnt <= pulse_len on the same edge, whether or not the data value changes.
  - While cnt != 0 and there is no such write, cnt decrements by 1 each cycle.
  - out_strobe is registered and equals busy. It rises the cycle after the write edge and stays high exactly pulse_len cycles.
  - pulse_len = 0 produces no strobe.
  - A data write during an active pulse reloads cnt and restarts the pulse. The pulse is extended, not doubled.
  - A write to addr 1 during a pulse changes only future pulses; the running cnt is unaffected.
  - A write to addr 1 never starts a pulse.
- out_port is driven directly from the data register and changes on the same edge as the write.
- Reset (asynchronous, mid-operation included):
  - data = RESET_VALUE, pulse_len = PULSE_RESET, cnt = 0.
  - out_strobe = 0, readdata = 0.
  - Any in-progress pulse is aborted immediately.
- The slave never initiates transfers and has no waitrequest.

Optional Feature:
- Macro: MAX10NIOS_VOTINGCTRL_AUTOCLR_EN.
- Defined:
  - On the edge where cnt transitions 1 -> 0 with no concurrent data write, data reloads to RESET_VALUE. The command auto-retracts when the strobe ends.
  - A concurrent data write on that edge wins: new data is taken and cnt is reloaded.
  - With pulse_len = 0, data never auto-clears.
- Not defined: data holds until the next software write. The cnt terminal edge has no effect on data.

Test Plan:
- Reset check: assert reset_n=0 mid-pulse (cnt=5). Required response: out_strobe=0, out_port=RESET_VALUE, readdata=0 asynchronously. After release, a read of addr 1 returns 0x00000001.
- Basic write and readback: write addr0=0x1, then read addr0. Required response: out_port=1 on the write edge; readdata=0x00000001 one cycle after the read address is applied. out_strobe is high for exactly 1 cycle, starting the cycle after the write.
- Programmable pulse: write addr1=0x0004, then addr2 (OUTSET)=0x1. Required response: out_strobe high 4 cycles. A read of addr1 during the pulse returns 0x80000004; after the pulse it returns 0x00000004. A read of addr2 returns the cnt sequence 4,3,2,1,0.
- Retrigger and late length change: with pulse_len=4, write addr3 (OUTCLEAR)=0x1 at cycle 0, addr1=0x0008 at cycle 1, and addr0=0x1 at cycle 2. Required response: out_port=0 at cycle 0, then 1 at cycle 2. out_strobe is continuously high from cycle 1 through cycle 10, because the cycle-2 reload uses the new pulse_len=8.
- Zero length: write addr1=0, then addr0=0x1. Required response: out_strobe never asserts, busy=0, out_port=1.
- AUTOCLR_EN: with pulse_len=3, write addr0=0x1. Required response: out_port returns to 0 on the edge where the strobe falls. A repeat with an addr0=0x1 write on the terminal edge leaves out_port=1 and restarts a 3-cycle strobe.
